// File: rtl/matrix_arbiter_pkg.sv
// Shared types and constants for the LED-matrix ownership arbiter.
package matrix_arbiter_pkg;

    localparam int unsigned MATRIX_DIM_X = 6;
    localparam int unsigned MATRIX_DIM_Y = 6;
    localparam int unsigned IMG_W        = MATRIX_DIM_X * MATRIX_DIM_Y;
    localparam int unsigned NUM_REQ      = 3;
    localparam logic [1:0]  OWNER_NONE   = 2'd3;

    typedef enum logic {
        StIdle = 1'b0,
        StOwn  = 1'b1
    } state_e;

    // Round-robin successor over requesters 0..2.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
        case (oh)
            3'b001:  return 2'd0;
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return OWNER_NONE;
        endcase
    endfunction

    function automatic logic [IMG_W-1:0] sel_img(input logic [1:0]       idx,
                                                 input logic [IMG_W-1:0] i0,
                                                 input logic [IMG_W-1:0] i1,
                                                 input logic [IMG_W-1:0] i2);
        case (idx)
            2'd0:    return i0;
            2'd1:    return i1;
            2'd2:    return i2;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/matrix_arbiter_if.sv
// Requester/scanner side bundle of the matrix arbiter.
interface matrix_arbiter_if;
    import matrix_arbiter_pkg::*;

    logic                 frame_done;
    logic [NUM_REQ-1:0]   req;
    logic [IMG_W-1:0]     img0;
    logic [IMG_W-1:0]     img1;
    logic [IMG_W-1:0]     img2;
    logic [NUM_REQ-1:0]   gnt;
    logic [1:0]           owner;
    logic [IMG_W-1:0]     img_out;
    logic                 handover;

    modport master (
        output frame_done, req, img0, img1, img2,
        input  gnt, owner, img_out, handover
    );

    modport slave (
        input  frame_done, req, img0, img1, img2,
        output gnt, owner, img_out, handover
    );

endinterface

// File: rtl/matrix_arbiter_rr_picker.sv
// Combinational 3-way round-robin picker: first set mask bit at or after start.
module rr_picker
    import matrix_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] mask,
    input  logic [1:0]         start,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = start;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!valid && mask[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
            idx = rr_next(idx);
        end
    end

endmodule

// File: rtl/matrix_arbiter.sv
// Frame-synchronous ownership arbiter for a 6x6 LED matrix; all state lives here and
// every decision is taken only on the scanner's frame_done pulse.
module matrix_arbiter
    import matrix_arbiter_pkg::*;
#(
    parameter int unsigned      HOLD_FRAMES = 4,
    parameter logic [IMG_W-1:0] IDLE_IMG    = 36'd0
) (
    input  logic             clk,
    input  logic             rst,
    matrix_arbiter_if.slave  bus
);

    localparam logic [3:0] HoldLast = 4'(HOLD_FRAMES - 1);
    localparam logic [3:0] HoldMax  = 4'(HOLD_FRAMES);

    state_e               state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic [1:0]           owner_q;
    logic [1:0]           last_owner_q;
    logic [3:0]           frame_cnt_q;
    logic [IMG_W-1:0]     img_q;
    logic                 handover_q;

    logic [NUM_REQ-1:0]   pick_mask;
    logic [NUM_REQ-1:0]   winner;
    logic                 win_valid;
    logic [1:0]           win_idx;
    logic                 owner_req;
    logic                 do_grant;
    logic                 do_release;

    // In OWN the current owner is masked out, so the picker only ever offers a change.
    always_comb begin
        pick_mask = (state_q == StOwn) ? (bus.req & ~gnt_q) : bus.req;
    end

    rr_picker u_rr_picker (
        .mask   (pick_mask),
        .start  (rr_next(last_owner_q)),
        .winner (winner),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx    = onehot_to_idx(winner);
        owner_req  = |(bus.req & gnt_q);
        do_grant   = 1'b0;
        do_release = 1'b0;
        if (bus.frame_done) begin
            if (state_q == StIdle) begin
                do_grant = win_valid;
            end else if (win_valid && (!owner_req || frame_cnt_q >= HoldLast)) begin
                do_grant = 1'b1;
            end else if (!owner_req) begin
                do_release = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            gnt_q        <= '0;
            owner_q      <= OWNER_NONE;
            last_owner_q <= 2'd2;
            frame_cnt_q  <= '0;
            img_q        <= IDLE_IMG;
            handover_q   <= 1'b0;
        end else begin
            handover_q <= 1'b0;
            if (do_grant) begin
                state_q      <= StOwn;
                gnt_q        <= winner;
                owner_q      <= win_idx;
                last_owner_q <= win_idx;
                frame_cnt_q  <= '0;
                img_q        <= sel_img(win_idx, bus.img0, bus.img1, bus.img2);
                handover_q   <= 1'b1;
            end else if (do_release) begin
                state_q     <= StIdle;
                gnt_q       <= '0;
                owner_q     <= OWNER_NONE;
                frame_cnt_q <= '0;
                img_q       <= IDLE_IMG;
                handover_q  <= 1'b1;
            end else if (bus.frame_done && state_q == StOwn) begin
                img_q <= sel_img(owner_q, bus.img0, bus.img1, bus.img2);
                if (frame_cnt_q < HoldMax) begin
                    frame_cnt_q <= frame_cnt_q + 4'd1;
                end
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.owner    = owner_q;
    assign bus.img_out  = img_q;
    assign bus.handover = handover_q;

endmodule

// File: tb/tb_matrix_arbiter.sv
// Directed bench for matrix_arbiter: one instance at HOLD_FRAMES=4, one at HOLD_FRAMES=1.
module tb_matrix_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    matrix_arbiter_if a_if ();
    matrix_arbiter_if b_if ();

    matrix_arbiter #(.HOLD_FRAMES(4), .IDLE_IMG(36'd0)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    matrix_arbiter #(.HOLD_FRAMES(1), .IDLE_IMG(36'd0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        a_if.frame_done = 1'b1;
        tick();
        a_if.frame_done = 1'b0;
    endtask

    task automatic pulse_b();
        b_if.frame_done = 1'b1;
        tick();
        b_if.frame_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_if.frame_done = 1'b0; a_if.req = 3'b000;
        a_if.img0 = 36'h0; a_if.img1 = 36'hF; a_if.img2 = 36'h3;
        b_if.frame_done = 1'b0; b_if.req = 3'b111;
        b_if.img0 = 36'hA; b_if.img1 = 36'hB; b_if.img2 = 36'hC;
        tick();
        tick();
        check("rst_gnt", a_if.gnt, 3'b000);
        check("rst_owner", a_if.owner, 2'd3);
        check("rst_img", a_if.img_out, 36'h0);
        check("rst_handover", a_if.handover, 1'b0);
        rst = 1'b0;

        // Idle to grant; nothing moves without frame_done.
        a_if.req = 3'b010;
        tick();
        check("no_fd_gnt", a_if.gnt, 3'b000);
        pulse_a();
        check("grant_gnt", a_if.gnt, 3'b010);
        check("grant_owner", a_if.owner, 2'd1);
        check("grant_img", a_if.img_out, 36'hF);
        check("grant_handover", a_if.handover, 1'b1);
        tick();
        check("handover_clear", a_if.handover, 1'b0);
        check("grant_hold", a_if.gnt, 3'b010);

        // Sole requester keeps ownership with no handover.
        for (int i = 0; i < 3; i++) begin
            pulse_a();
            check("sole_gnt", a_if.gnt, 3'b010);
            check("sole_handover", a_if.handover, 1'b0);
        end

        // Release to idle.
        a_if.req = 3'b000;
        pulse_a();
        check("rel_gnt", a_if.gnt, 3'b000);
        check("rel_owner", a_if.owner, 2'd3);
        check("rel_img", a_if.img_out, 36'h0);
        check("rel_handover", a_if.handover, 1'b1);

        // No tearing: image change between pulses is invisible until the next pulse.
        a_if.img0 = 36'h1;
        a_if.req = 3'b001;
        pulse_a();
        check("tear_owner", a_if.owner, 2'd0);
        check("tear_img_a", a_if.img_out, 36'h1);
        a_if.img0 = 36'h2;
        tick();
        tick();
        check("tear_img_hold", a_if.img_out, 36'h1);
        pulse_a();
        check("tear_img_b", a_if.img_out, 36'h2);

        // Hold-off: fresh grant to 0, then 1 competes; switch on the 4th pulse.
        a_if.req = 3'b000;
        pulse_a();
        check("hold_idle", a_if.gnt, 3'b000);
        a_if.req = 3'b001;
        pulse_a();
        check("hold_grant0", a_if.gnt, 3'b001);
        a_if.req = 3'b011;
        for (int i = 1; i <= 3; i++) begin
            pulse_a();
            check("hold_keep", a_if.gnt, 3'b001);
        end
        pulse_a();
        check("hold_switch_gnt", a_if.gnt, 3'b010);
        check("hold_switch_owner", a_if.owner, 2'd1);
        check("hold_switch_handover", a_if.handover, 1'b1);

        // Owner drops, other requester picked up immediately.
        a_if.req = 3'b100;
        pulse_a();
        check("drop_to2", a_if.gnt, 3'b100);
        check("drop_to2_img", a_if.img_out, 36'h3);
        a_if.req = 3'b001;
        pulse_a();
        check("drop_to0_gnt", a_if.gnt, 3'b001);
        check("drop_to0_owner", a_if.owner, 2'd0);
        check("drop_to0_img", a_if.img_out, 36'h2);

        // req changing on the frame_done edge is taken as sampled.
        a_if.req = 3'b010;
        pulse_a();
        check("same_edge_owner", a_if.owner, 2'd1);
        check("same_edge_img", a_if.img_out, 36'hF);
        tick();

        // Reset mid-ownership abandons silently; arbitration resumes on next pulse.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_gnt", a_if.gnt, 3'b000);
        check("midrst_owner", a_if.owner, 2'd3);
        check("midrst_handover", a_if.handover, 1'b0);
        check("midrst_img", a_if.img_out, 36'h0);
        tick();
        check("midrst_wait", a_if.gnt, 3'b000);
        pulse_a();
        check("midrst_regrant", a_if.gnt, 3'b010);
        check("midrst_regrant_owner", a_if.owner, 2'd1);

        // HOLD_FRAMES=1, all requesting: owners rotate 0,1,2,0.
        pulse_b();
        check("wrap_o0", b_if.owner, 2'd0);
        check("wrap_img0", b_if.img_out, 36'hA);
        pulse_b();
        check("wrap_o1", b_if.owner, 2'd1);
        pulse_b();
        check("wrap_o2", b_if.owner, 2'd2);
        check("wrap_img2", b_if.img_out, 36'hC);
        pulse_b();
        check("wrap_o3", b_if.owner, 2'd0);
        check("wrap_gnt3", b_if.gnt, 3'b001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_arbiter.md
MATRIX_ARBITER -- requirements
Module: matrix_arbiter

Interface
REQ-001 Parameter HOLD_FRAMES, default 4: minimum frames an owner keeps the matrix while another requester waits; legal range 1..15.
REQ-002 Parameter IDLE_IMG, default 36'd0: image driven when no requester owns the matrix.
REQ-003 clk  input  1  system clock; the block uses one clock only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 frame_done  input  1  one-cycle pulse from the matrix scanner at the end of a full 6-row scan.
REQ-006 req  input  3  per-requester request, level-sensitive; bit i belongs to requester i.
REQ-007 img0, img1, img2  input  36  requester images, row-major, bits [5:0] = top row.
REQ-008 gnt  output  3  one-hot grant, or all-zero when idle.
REQ-009 owner  output  2  index of the current owner; 2'd3 when idle.
REQ-010 img_out  output  36  registered image to the led_matrix driver.
REQ-011 handover  output  1  one-cycle pulse on the cycle after any ownership change.

Function
REQ-012 The FSM SHALL have two states, IDLE and OWN; all decisions SHALL be taken only on cycles where frame_done=1, and no output SHALL change on any other cycle except for handover clearing.
REQ-013 In IDLE with frame_done=1 and req!=0, the block SHALL grant the round-robin winner, load img_out from that requester's image, clear frame_cnt, and enter OWN; with req=0 it SHALL stay in IDLE with img_out=IDLE_IMG.
REQ-014 Round-robin order SHALL start searching at (last_owner+1) mod 3 and wrap 2->0; last_owner SHALL update on every grant.
REQ-015 In OWN, on frame_done, if the owner's req=0:
- grant the round-robin winner of the remaining requests, or
- return to IDLE with gnt=0, owner=3, img_out=IDLE_IMG if no other request is pending.
REQ-016 In OWN, on frame_done, if the owner's req=1 and another req is high and frame_cnt>=HOLD_FRAMES-1, the block SHALL switch to the round-robin winner among the other requesters.
REQ-017 In OWN, on frame_done, in all other cases, the block SHALL keep the owner, reload img_out from the owner's image, and increment frame_cnt saturating at HOLD_FRAMES.
REQ-018 frame_cnt SHALL be 4 bits wide and SHALL clear on every grant change.
REQ-019 Latency: gnt, owner and img_out SHALL update on the clock edge at which frame_done=1 is sampled; handover SHALL be 1 during the following cycle only.
REQ-020 The owner's image SHALL be sampled only at frame_done; changes to img0-img2 between pulses SHALL NOT affect img_out, so there is no tearing.
REQ-021 When req changes in the same cycle as frame_done, the block SHALL use the req value sampled on that edge.
REQ-022 With a sole requester whose req stays high, the block SHALL hold ownership indefinitely, and handover SHALL NOT pulse.
REQ-023 gnt SHALL always be one-hot or zero, and owner SHALL always be consistent with gnt.

Reset
REQ-024 While rst=1, at each clock edge:
- state=IDLE, gnt=0, owner=3, img_out=IDLE_IMG, handover=0
- frame_cnt=0, last_owner=2, so requester 0 is searched first
REQ-025 A rst asserted during OWN SHALL abandon ownership without a handover pulse; arbitration SHALL resume at the first frame_done after rst deasserts.

Structure
REQ-026 A shared package SHALL hold MATRIX_DIM_X=6, MATRIX_DIM_Y=6, IMG_W=36, the IDLE/OWN state encodings, and OWNER_NONE=2'd3.
REQ-027 One sub-module, rr_picker, SHALL be used: combinational 3-way round-robin selection taking the request mask and start index and returning a one-hot winner plus a valid flag.
REQ-028 matrix_arbiter SHALL contain all state, counters and image registers.

Verification
REQ-029 Idle to grant: req=3'b010, img1=36'hF, first frame_done -> gnt=3'b010, owner=1, img_out=36'hF, handover=1 on the next cycle.
REQ-030 Hold-off: owner 0 with req=3'b011 held -> switch to gnt=3'b010 exactly at the 4th frame_done after grant (HOLD_FRAMES=4), not before.
REQ-031 Release: owner 2 drops req while req=3'b001 -> next frame_done gives gnt=3'b001; if req=0 instead, gnt=0, owner=3, img_out=0.
REQ-032 Round-robin wrap: req=3'b111 held, HOLD_FRAMES=1 -> owners 0,1,2,0 on successive frame_done pulses.
REQ-033 No tearing: change img0 mid-frame from 36'h1 to 36'h2 -> img_out stays 36'h1 until the next frame_done, then becomes 36'h2.
REQ-034 Reset mid-ownership: rst pulsed while owner=1 -> gnt=0, owner=3, handover=0; after release with req=3'b010, the next frame_done grants requester 1.
